// File: rtl/alu_resp_pipe.sv
// ALU responder: accepts {a, b, cntrl, tag} requests and returns {result, flags, tag}.
// Latency: a request accepted at edge k shows out_valid after edge k+1 and can retire at edge k+2.
// Backpressure: 2-stage elastic pipe with full throughput; in_ready falls only when both stages hold data and out_ready=0.
module alu_resp_pipe #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_cntrl,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_neg,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_cout,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;

   // S1: request register
   logic             s1_v_q,     s1_v_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   logic [2:0]       s1_cntrl_q, s1_cntrl_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

   // S2: response register, drives the out_* port directly
   logic             s2_v_q,      s2_v_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic             s2_neg_q,    s2_neg_d;
   logic             s2_zero_q,   s2_zero_d;
   logic             s2_ovf_q,    s2_ovf_d;
   logic             s2_cout_q,   s2_cout_d;
   logic             s2_err_q,    s2_err_d;
   logic [TAG_W-1:0] s2_tag_q,    s2_tag_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // ALU outputs for the operation held in S1
   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;
   logic             alu_cout;
   logic             alu_err;
   logic [WIDTH:0]   alu_sum;
   logic [WIDTH-1:0] alu_b_op;
   logic             alu_sub;

   logic s2_ready;
   logic in_fire;
   logic s1_adv;
   logic out_fire;

   assign s2_ready = !s2_v_q || out_ready;
   assign in_ready = !s1_v_q || s2_ready;
   assign in_fire  = in_valid && in_ready;
   assign s1_adv   = s1_v_q && s2_ready;
   assign out_fire = s2_v_q && out_ready;

   // Shared adder: subtraction is A + ~B + 1, so carry-out set means no borrow
   always_comb begin
      alu_sub    = (s1_cntrl_q == OP_SUB);
      alu_b_op   = alu_sub ? ~s1_b_q : s1_b_q;
      alu_sum    = {1'b0, s1_a_q} + {1'b0, alu_b_op} + {{WIDTH{1'b0}}, alu_sub};
      alu_result = '0;
      alu_ovf    = 1'b0;
      alu_cout   = 1'b0;
      alu_err    = 1'b0;
      case (s1_cntrl_q)
         OP_PASS: alu_result = s1_b_q;
         OP_ADD: begin
            alu_result = alu_sum[WIDTH-1:0];
            alu_cout   = alu_sum[WIDTH];
            alu_ovf    = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                         (alu_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_result = alu_sum[WIDTH-1:0];
            alu_cout   = alu_sum[WIDTH];
            alu_ovf    = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                         (alu_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OP_AND:  alu_result = s1_a_q & s1_b_q;
         OP_OR:   alu_result = s1_a_q | s1_b_q;
         OP_XOR:  alu_result = s1_a_q ^ s1_b_q;
         default: alu_err    = 1'b1;
      endcase
   end

   // Next-state for both stages and the completion counter
   always_comb begin
      s1_v_d      = s1_v_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_cntrl_d  = s1_cntrl_q;
      s1_tag_d    = s1_tag_q;
      s2_v_d      = s2_v_q;
      s2_result_d = s2_result_q;
      s2_neg_d    = s2_neg_q;
      s2_zero_d   = s2_zero_q;
      s2_ovf_d    = s2_ovf_q;
      s2_cout_d   = s2_cout_q;
      s2_err_d    = s2_err_q;
      s2_tag_d    = s2_tag_q;
      cnt_d       = cnt_q;

      // capture wins over drain so S1 can advance and refill in the same cycle
      if (in_fire) begin
         s1_v_d     = 1'b1;
         s1_a_d     = in_a;
         s1_b_d     = in_b;
         s1_cntrl_d = in_cntrl;
         s1_tag_d   = in_tag;
      end else if (s1_adv) begin
         s1_v_d = 1'b0;
      end

      // S2 payload only changes when S2 is free to take a new entry, keeping it stable while stalled
      if (s2_ready) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_result_d = alu_result;
            s2_neg_d    = alu_result[WIDTH-1];
            s2_zero_d   = (alu_result == '0);
            s2_ovf_d    = alu_ovf;
            s2_cout_d   = alu_cout;
            s2_err_d    = alu_err;
            s2_tag_d    = s1_tag_q;
         end
      end

      if (out_fire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Pipeline and counter state; reset discards anything in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v_q      <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_cntrl_q  <= '0;
         s1_tag_q    <= '0;
         s2_v_q      <= 1'b0;
         s2_result_q <= '0;
         s2_neg_q    <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_ovf_q    <= 1'b0;
         s2_cout_q   <= 1'b0;
         s2_err_q    <= 1'b0;
         s2_tag_q    <= '0;
         cnt_q       <= '0;
      end else begin
         s1_v_q      <= s1_v_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_cntrl_q  <= s1_cntrl_d;
         s1_tag_q    <= s1_tag_d;
         s2_v_q      <= s2_v_d;
         s2_result_q <= s2_result_d;
         s2_neg_q    <= s2_neg_d;
         s2_zero_q   <= s2_zero_d;
         s2_ovf_q    <= s2_ovf_d;
         s2_cout_q   <= s2_cout_d;
         s2_err_q    <= s2_err_d;
         s2_tag_q    <= s2_tag_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid  = s2_v_q;
   assign out_result = s2_result_q;
   assign out_neg    = s2_neg_q;
   assign out_zero   = s2_zero_q;
   assign out_ovf    = s2_ovf_q;
   assign out_cout   = s2_cout_q;
   assign out_err    = s2_err_q;
   assign out_tag    = s2_tag_q;
   assign op_count   = cnt_q;

endmodule
